multisim_axi_pull_bridge: RTL and testbench

//  Simulation-only AXI manager endpoint driven by a remote multisim client process over DPI.

---
 rtl/multisim_dpi_pkg.sv | 123 ++++++++++++
 rtl/multisim_server_pull_channel.sv | 35 +++
 rtl/multisim_axi_pull_bridge.sv | 108 ++++++++++
 tb/tb_multisim_axi_pull_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_dpi_pkg.sv
// Transport prototypes for the multisim client link, backed by an in-process scripted client.
// Per-channel queues stand in for the remote process; helper calls let a host script them.
package multisim_dpi_pkg;

  localparam int unsigned MAX_W  = 256;
  localparam int unsigned MAX_CH = 16;

  typedef logic [MAX_W-1:0] beat_t;

  int unsigned chan_ids [string];
  int unsigned n_chan = 0;
  beat_t       pull_q      [MAX_CH][$];
  beat_t       push_log    [MAX_CH][$];
  int unsigned pull_calls  [MAX_CH];
  int unsigned push_fails  [MAX_CH];
  int unsigned start_calls [MAX_CH];

  // Channels register on first mention, so call order across blocks in one edge is irrelevant.
  function automatic int unsigned chan_of(string name);
    if (!chan_ids.exists(name)) begin
      if (n_chan >= MAX_CH) return MAX_CH - 1;
      chan_ids[name] = n_chan;
      n_chan++;
    end
    return chan_ids[name];
  endfunction

  function automatic beat_t trim(beat_t d, int unsigned width);
    beat_t t = d;
    for (int unsigned i = width; i < MAX_W; i++) t[i] = 1'b0;
    return t;
  endfunction

  function automatic void multisim_server_start(string name);
    start_calls[chan_of(name)]++;
  endfunction

  function automatic int stub_take(string name, int unsigned width, output beat_t data);
    int unsigned c = chan_of(name);
    pull_calls[c]++;
    data = '0;
    if (pull_q[c].size() == 0) return 0;
    data = trim(pull_q[c].pop_front(), width);
    return 1;
  endfunction

  function automatic int stub_give(string name, int unsigned width, beat_t data);
    int unsigned c = chan_of(name);
    if (push_fails[c] > 0) begin
      push_fails[c]--;
      return 0;
    end
    push_log[c].push_back(trim(data, width));
    return 1;
  endfunction

  function automatic int multisim_server_pull(string name, int unsigned width,
                                              output bit [MAX_W-1:0] data);
    beat_t t;
    int    ok;
    ok   = stub_take(name, width, t);
    data = t;
    return ok;
  endfunction

  function automatic int multisim_server_pull_4state(string name, int unsigned width,
                                                     output logic [MAX_W-1:0] data);
    return stub_take(name, width, data);
  endfunction

  function automatic int multisim_server_push(string name, int unsigned width,
                                              input bit [MAX_W-1:0] data);
    return stub_give(name, width, beat_t'(data));
  endfunction

  function automatic int multisim_server_push_4state(string name, int unsigned width,
                                                     input logic [MAX_W-1:0] data);
    return stub_give(name, width, data);
  endfunction

  function automatic int multisim_pull_any(string name, int unsigned width, int unsigned is_4state,
                                           output logic [MAX_W-1:0] data);
    bit [MAX_W-1:0] data2;
    int             ok;
    if (is_4state != 0) return multisim_server_pull_4state(name, width, data);
    ok   = multisim_server_pull(name, width, data2);
    data = data2;
    return ok;
  endfunction

  function automatic int multisim_push_any(string name, int unsigned width, int unsigned is_4state,
                                           input logic [MAX_W-1:0] data);
    if (is_4state != 0) return multisim_server_push_4state(name, width, data);
    return multisim_server_push(name, width, data);
  endfunction

  function automatic void stub_queue(string name, beat_t data);
    pull_q[chan_of(name)].push_back(data);
  endfunction

  function automatic void stub_fail_pushes(string name, int unsigned n);
    push_fails[chan_of(name)] = n;
  endfunction

  function automatic int unsigned stub_pull_calls(string name);
    return pull_calls[chan_of(name)];
  endfunction

  function automatic int unsigned stub_start_count(string name);
    return start_calls[chan_of(name)];
  endfunction

  function automatic int unsigned stub_push_count(string name);
    return push_log[chan_of(name)].size();
  endfunction

  function automatic beat_t stub_push_pop(string name);
    int unsigned c = chan_of(name);
    if (push_log[c].size() == 0) return '0;
    return push_log[c].pop_front();
  endfunction

endpackage

// File: rtl/multisim_server_pull_channel.sv
// One pulled channel: a valid/data register refilled from the client whenever it is empty or draining.
module multisim_server_pull_channel
  import multisim_dpi_pkg::*;
#(
  parameter type         T              = logic [31:0],
  parameter int unsigned DATA_IS_4STATE = 0,
  parameter string       SUFFIX         = "_x"
) (
  input  logic  clk,
  input  logic  rst_n,
  input  string server_name,
  output T      data,
  output logic  valid,
  input  logic  ready
);

  localparam int unsigned W = $bits(T);

  always_ff @(posedge clk) begin : pull_seq
    beat_t beat;
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (!valid || ready) begin
      // A failed pull leaves the payload as-is; only valid drops.
      if (multisim_pull_any({server_name, SUFFIX}, W, DATA_IS_4STATE, beat) != 0) begin
        valid <= 1'b1;
        data  <= T'(W'(beat));
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multisim_axi_pull_bridge.sv
// AXI manager endpoint driven by a multisim client: AW/W/AR are pulled, B/R are pushed back.
module multisim_axi_pull_bridge
  import multisim_dpi_pkg::*;
#(
  parameter int unsigned DATA_IS_4STATE = 0,
  parameter type         axi_aw_t       = logic [31:0],
  parameter type         axi_w_t        = logic [31:0],
  parameter type         axi_b_t        = logic [31:0],
  parameter type         axi_ar_t       = logic [31:0],
  parameter type         axi_r_t        = logic [31:0]
) (
  input  logic    clk,
  input  logic    rst_n,
  input  string   server_name,
  output axi_aw_t o_axi_m_aw,
  input  logic    i_axi_m_awready,
  output logic    o_axi_m_awvalid,
  output axi_w_t  o_axi_m_w,
  input  logic    i_axi_m_wready,
  output logic    o_axi_m_wvalid,
  input  axi_b_t  i_axi_m_b,
  output logic    o_axi_m_bready,
  input  logic    i_axi_m_bvalid,
  output axi_ar_t o_axi_m_ar,
  input  logic    i_axi_m_arready,
  output logic    o_axi_m_arvalid,
  input  axi_r_t  i_axi_m_r,
  output logic    o_axi_m_rready,
  input  logic    i_axi_m_rvalid
);

  localparam int unsigned BW = $bits(axi_b_t);
  localparam int unsigned RW = $bits(axi_r_t);

  // Channel registration happens on the very first edge regardless of reset.
  logic started;
  always_ff @(posedge clk) begin
    if (started !== 1'b1) begin
      multisim_server_start({server_name, "_aw"});
      multisim_server_start({server_name, "_w"});
      multisim_server_start({server_name, "_b"});
      multisim_server_start({server_name, "_ar"});
      multisim_server_start({server_name, "_r"});
      started <= 1'b1;
    end
  end

  multisim_server_pull_channel #(
    .T(axi_aw_t), .DATA_IS_4STATE(DATA_IS_4STATE), .SUFFIX("_aw")
  ) u_aw (
    .clk(clk), .rst_n(rst_n), .server_name(server_name),
    .data(o_axi_m_aw), .valid(o_axi_m_awvalid), .ready(i_axi_m_awready)
  );

  multisim_server_pull_channel #(
    .T(axi_w_t), .DATA_IS_4STATE(DATA_IS_4STATE), .SUFFIX("_w")
  ) u_w (
    .clk(clk), .rst_n(rst_n), .server_name(server_name),
    .data(o_axi_m_w), .valid(o_axi_m_wvalid), .ready(i_axi_m_wready)
  );

  multisim_server_pull_channel #(
    .T(axi_ar_t), .DATA_IS_4STATE(DATA_IS_4STATE), .SUFFIX("_ar")
  ) u_ar (
    .clk(clk), .rst_n(rst_n), .server_name(server_name),
    .data(o_axi_m_ar), .valid(o_axi_m_arvalid), .ready(i_axi_m_arready)
  );

  logic   b_pend;
  axi_b_t b_hold;
  assign o_axi_m_bready = rst_n && !b_pend;

  // A rejected beat parks in the hold register and ready stays low until the retry lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_pend <= 1'b0;
      b_hold <= '0;
    end else if (b_pend) begin
      if (multisim_push_any({server_name, "_b"}, BW, DATA_IS_4STATE, MAX_W'(b_hold)) != 0)
        b_pend <= 1'b0;
    end else if (i_axi_m_bvalid) begin
      if (multisim_push_any({server_name, "_b"}, BW, DATA_IS_4STATE, MAX_W'(i_axi_m_b)) == 0) begin
        b_pend <= 1'b1;
        b_hold <= i_axi_m_b;
      end
    end
  end

  logic   r_pend;
  axi_r_t r_hold;
  assign o_axi_m_rready = rst_n && !r_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_hold <= '0;
    end else if (r_pend) begin
      if (multisim_push_any({server_name, "_r"}, RW, DATA_IS_4STATE, MAX_W'(r_hold)) != 0)
        r_pend <= 1'b0;
    end else if (i_axi_m_rvalid) begin
      if (multisim_push_any({server_name, "_r"}, RW, DATA_IS_4STATE, MAX_W'(i_axi_m_r)) == 0) begin
        r_pend <= 1'b1;
        r_hold <= i_axi_m_r;
      end
    end
  end

endmodule

// File: tb/tb_multisim_axi_pull_bridge.sv
// Directed bench for multisim_axi_pull_bridge: a 2-state instance and a 4-state instance share the scripted client.
module tb_multisim_axi_pull_bridge;
  import multisim_dpi_pkg::*;

  typedef struct packed { logic [31:0] addr; logic [3:0] id; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] id; } ar_t;
  typedef struct packed { logic [31:0] data; logic [3:0] id; logic [1:0] resp; logic last; } r_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  string name0 = "m";
  string name4 = "q";

  logic rst_n, rst4_n;
  aw_t aw;  logic awready, awvalid;
  w_t  w;   logic wready, wvalid;
  b_t  b;   logic bready, bvalid;
  ar_t ar;  logic arready, arvalid;
  r_t  r;   logic rready, rvalid;
  aw_t aw4; logic awready4, awvalid4;
  w_t  w4;  logic wready4, wvalid4;
  b_t  b4;  logic bready4, bvalid4;
  ar_t ar4; logic arready4, arvalid4;
  r_t  r4;  logic rready4, rvalid4;

  int total = 0;
  int bad   = 0;

  multisim_axi_pull_bridge #(
    .DATA_IS_4STATE(0), .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t), .axi_ar_t(ar_t), .axi_r_t(r_t)
  ) dut (
    .clk(clk), .rst_n(rst_n), .server_name(name0),
    .o_axi_m_aw(aw), .i_axi_m_awready(awready), .o_axi_m_awvalid(awvalid),
    .o_axi_m_w(w), .i_axi_m_wready(wready), .o_axi_m_wvalid(wvalid),
    .i_axi_m_b(b), .o_axi_m_bready(bready), .i_axi_m_bvalid(bvalid),
    .o_axi_m_ar(ar), .i_axi_m_arready(arready), .o_axi_m_arvalid(arvalid),
    .i_axi_m_r(r), .o_axi_m_rready(rready), .i_axi_m_rvalid(rvalid)
  );

  multisim_axi_pull_bridge #(
    .DATA_IS_4STATE(1), .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t), .axi_ar_t(ar_t), .axi_r_t(r_t)
  ) dut4 (
    .clk(clk), .rst_n(rst4_n), .server_name(name4),
    .o_axi_m_aw(aw4), .i_axi_m_awready(awready4), .o_axi_m_awvalid(awvalid4),
    .o_axi_m_w(w4), .i_axi_m_wready(wready4), .o_axi_m_wvalid(wvalid4),
    .i_axi_m_b(b4), .o_axi_m_bready(bready4), .i_axi_m_bvalid(bvalid4),
    .o_axi_m_ar(ar4), .i_axi_m_arready(arready4), .o_axi_m_arvalid(arvalid4),
    .i_axi_m_r(r4), .o_axi_m_rready(rready4), .i_axi_m_rvalid(rvalid4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    aw_t a;
    a = '{addr: 32'h1000, id: 4'h0};
    stub_queue("m_aw", MAX_W'(a));
    repeat (5) tick();
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid got=%b want=0", awvalid); end
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b want=0", wvalid); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", arvalid); end
    total++; if (bready !== 1'b0) begin bad++; $display("FAIL rst_bready got=%b want=0", bready); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", rready); end
    total++; if (stub_pull_calls("m_aw") != 0) begin bad++; $display("FAIL rst_pulls got=%0d want=0", stub_pull_calls("m_aw")); end
    total++; if (stub_start_count("m_r") != 1) begin bad++; $display("FAIL start_once got=%0d want=1", stub_start_count("m_r")); end
    rst_n = 1'b1;
    #1;
    total++; if (bready !== 1'b1) begin bad++; $display("FAIL rel_bready got=%b want=1", bready); end
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL rel_awvalid_early got=%b want=0", awvalid); end
    tick();
    total++; if (awvalid !== 1'b1 || aw.addr !== 32'h1000) begin
      bad++; $display("FAIL rel_aw got=%b/%h want=1/00001000", awvalid, aw.addr); end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL rel_aw_drain got=%b want=0", awvalid); end
  endtask

  task automatic test_aw_burst;
    logic [31:0] exp_addr [3];
    aw_t a;
    exp_addr = '{32'h10, 32'h20, 32'h30};
    for (int i = 0; i < 3; i++) begin
      a = '{addr: exp_addr[i], id: 4'(i + 1)};
      stub_queue("m_aw", MAX_W'(a));
    end
    awready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (awvalid !== 1'b1 || aw.addr !== exp_addr[i] || aw.id !== 4'(i + 1)) begin
        bad++; $display("FAIL burst_beat%0d got=%b/%h want=1/%h", i, awvalid, aw.addr, exp_addr[i]); end
    end
    tick();
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL burst_end got=%b want=0", awvalid); end
    awready = 1'b0;
  endtask

  task automatic test_ar_stall;
    ar_t a;
    int unsigned c;
    a = '{addr: 32'h40, id: 4'h4};
    arready = 1'b0;
    stub_queue("m_ar", MAX_W'(a));
    tick();
    total++; if (arvalid !== 1'b1 || ar.addr !== 32'h40) begin
      bad++; $display("FAIL ar_load got=%b/%h want=1/00000040", arvalid, ar.addr); end
    c = stub_pull_calls("m_ar");
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (arvalid !== 1'b1 || ar.addr !== 32'h40 || stub_pull_calls("m_ar") != c) begin
        bad++; $display("FAIL ar_hold%0d got=%b/%h/%0d want=1/00000040/%0d", i, arvalid, ar.addr,
                        stub_pull_calls("m_ar"), c); end
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    total++; if (arvalid !== 1'b0 || stub_pull_calls("m_ar") != c + 1) begin
      bad++; $display("FAIL ar_release got=%b/%0d want=0/%0d", arvalid, stub_pull_calls("m_ar"), c + 1); end
  endtask

  task automatic test_r_backpressure;
    r_t exp;
    beat_t got;
    exp = '{data: 32'hDEADBEEF, id: 4'h5, resp: 2'b00, last: 1'b1};
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL r_idle_ready got=%b want=1", rready); end
    stub_fail_pushes("m_r", 2);
    r = exp;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    r = '0;
    total++; if (rready !== 1'b0 || stub_push_count("m_r") != 0) begin
      bad++; $display("FAIL r_fail1 got=%b/%0d want=0/0", rready, stub_push_count("m_r")); end
    tick();
    total++; if (rready !== 1'b0 || stub_push_count("m_r") != 0) begin
      bad++; $display("FAIL r_fail2 got=%b/%0d want=0/0", rready, stub_push_count("m_r")); end
    tick();
    total++; if (rready !== 1'b1 || stub_push_count("m_r") != 1) begin
      bad++; $display("FAIL r_retry got=%b/%0d want=1/1", rready, stub_push_count("m_r")); end
    got = stub_push_pop("m_r");
    total++; if (got !== MAX_W'(exp)) begin
      bad++; $display("FAIL r_payload got=%h want=%h", got[38:0], exp); end
    tick();
    total++; if (rready !== 1'b1 || stub_push_count("m_r") != 0) begin
      bad++; $display("FAIL r_no_dup got=%b/%0d want=1/0", rready, stub_push_count("m_r")); end
  endtask

  task automatic test_all_five;
    aw_t ea; w_t ew; ar_t er; b_t eb; r_t erd;
    beat_t got;
    ea  = '{addr: 32'h50, id: 4'h6};
    ew  = '{data: 32'hA5A5A5A5, strb: 4'hF, last: 1'b1};
    er  = '{addr: 32'h60, id: 4'h7};
    eb  = '{id: 4'h3, resp: 2'b10};
    erd = '{data: 32'h12345678, id: 4'h9, resp: 2'b01, last: 1'b1};
    stub_queue("m_aw", MAX_W'(ea));
    stub_queue("m_w", MAX_W'(ew));
    stub_queue("m_ar", MAX_W'(er));
    tick();
    total++; if (awvalid !== 1'b1 || aw !== ea) begin bad++; $display("FAIL five_aw got=%b/%h want=1/%h", awvalid, aw, ea); end
    total++; if (wvalid !== 1'b1 || w !== ew) begin bad++; $display("FAIL five_w got=%b/%h want=1/%h", wvalid, w, ew); end
    total++; if (arvalid !== 1'b1 || ar !== er) begin bad++; $display("FAIL five_ar got=%b/%h want=1/%h", arvalid, ar, er); end
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    b = eb; bvalid = 1'b1;
    r = erd; rvalid = 1'b1;
    #1;
    total++; if (bready !== 1'b1 || rready !== 1'b1) begin
      bad++; $display("FAIL five_readies got=%b%b want=11", bready, rready); end
    tick();
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    total++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin
      bad++; $display("FAIL five_drain got=%b%b%b want=000", awvalid, wvalid, arvalid); end
    total++; if (stub_push_count("m_b") != 1 || stub_push_count("m_r") != 1) begin
      bad++; $display("FAIL five_push_cnt got=%0d/%0d want=1/1", stub_push_count("m_b"), stub_push_count("m_r")); end
    got = stub_push_pop("m_b");
    total++; if (got !== MAX_W'(eb)) begin bad++; $display("FAIL five_b got=%h want=%h", got[5:0], eb); end
    got = stub_push_pop("m_r");
    total++; if (got !== MAX_W'(erd)) begin bad++; $display("FAIL five_r got=%h want=%h", got[38:0], erd); end
  endtask

  task automatic test_4state;
    w_t wx, wx2, wx3;
    r_t rx;
    beat_t got;
    int unsigned c;
    wx  = '{data: 32'hABx0z512, strb: 4'b1x0z, last: 1'bx};
    wx2 = '{data: 32'h12345678, strb: 4'hF, last: 1'b0};
    wx3 = '{data: 32'h0000CAFE, strb: 4'h3, last: 1'b1};
    rx  = '{data: 32'hx0z0_1111, id: 4'hz, resp: 2'bx1, last: 1'b1};
    stub_queue("q_w", MAX_W'(wx));
    stub_queue("q_w", MAX_W'(wx2));
    wready4 = 1'b0;
    rst4_n = 1'b1;
    tick();
    total++; if (wvalid4 !== 1'b1 || w4 !== wx) begin
      bad++; $display("FAIL x_w_beat0 got=%b/%h want=1/%h", wvalid4, w4, wx); end
    wready4 = 1'b1;
    tick();
    wready4 = 1'b0;
    total++; if (wvalid4 !== 1'b1 || w4 !== wx2) begin
      bad++; $display("FAIL x_w_beat1 got=%b/%h want=1/%h", wvalid4, w4, wx2); end
    stub_queue("q_w", MAX_W'(wx3));
    c = stub_pull_calls("q_w");
    rst4_n = 1'b0;
    tick();
    total++; if (wvalid4 !== 1'b0 || w4 !== '0) begin
      bad++; $display("FAIL x_w_reset got=%b/%h want=0/0", wvalid4, w4); end
    total++; if (stub_pull_calls("q_w") != c) begin
      bad++; $display("FAIL x_w_reset_pulls got=%0d want=%0d", stub_pull_calls("q_w"), c); end
    rst4_n = 1'b1;
    #1;
    r4 = rx;
    rvalid4 = 1'b1;
    tick();
    rvalid4 = 1'b0;
    total++; if (stub_push_count("q_r") != 1) begin
      bad++; $display("FAIL x_r_cnt got=%0d want=1", stub_push_count("q_r")); end
    got = stub_push_pop("q_r");
    total++; if (got !== MAX_W'(rx)) begin bad++; $display("FAIL x_r_payload got=%h want=%h", got[38:0], rx); end
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    b = '0; bvalid = 1'b0; r = '0; rvalid = 1'b0;
    awready4 = 1'b0; wready4 = 1'b0; arready4 = 1'b0;
    b4 = '0; bvalid4 = 1'b0; r4 = '0; rvalid4 = 1'b0;
    test_reset();
    test_aw_burst();
    test_ar_stall();
    test_r_backpressure();
    test_all_five();
    test_4state();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
